// File: rtl/dxm_trng_bit_collector_pkg.sv
// Shared TRNG constants and helpers for the bit collector.
// Default word geometry plus the repetition-count update rule.
package dxm_trng_bit_collector_pkg;

  localparam int unsigned DXM_WORD_W    = 32;
  localparam int unsigned DXM_CNT_W     = 16;
  localparam int unsigned DXM_REP_LIMIT = 32;
  localparam int unsigned DXM_REP_W     = 8;

  typedef logic [DXM_REP_W-1:0] rep_cnt_t;

  // Run length after one more sample: restart at 1 on a change, else count up and saturate.
  function automatic rep_cnt_t rep_next(input rep_cnt_t cur, input logic same);
    if (!same) begin
      return rep_cnt_t'(1);
    end
    if (cur == '1) begin
      return cur;
    end
    return cur + rep_cnt_t'(1);
  endfunction

endpackage

// File: rtl/dxm_sync_2ff.sv
// Two-stage bit synchronizer for a signal asynchronous to clk.
module dxm_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dxm_trng_bit_collector.sv
// Samples the synchronized ring-oscillator bit at a programmable rate, packs WORD_W bits per
// word (first sample in MSB), double-buffers into a valid/ready output and runs a repetition test.
module dxm_trng_bit_collector
  import dxm_trng_bit_collector_pkg::*;
#(
  parameter int unsigned WORD_W    = DXM_WORD_W,
  parameter int unsigned CNT_W     = DXM_CNT_W,
  parameter int unsigned REP_LIMIT = DXM_REP_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rosc_in,
  input  logic              enable,
  input  logic [CNT_W-1:0]  sample_cnt,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              stall,
  output logic              rep_err
);

  localparam int unsigned BC_W = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(WORD_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
  localparam rep_cnt_t REP_HIT = rep_cnt_t'(REP_LIMIT);

  logic              sync_bit;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] word_next;
  logic [BC_W-1:0]   bitcnt;
  rep_cnt_t          repcnt;
  rep_cnt_t          repcnt_nxt;
  logic              enable_q;
  logic              buf_free;
  logic              full;
  logic              stall_c;
  logic              sample;
  logic              completing;
  logic              load_buf;

  dxm_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rosc_in),
    .q     (sync_bit)
  );

  // Output handshake: data_out is held stable while data_valid=1; a word is consumed in any
  // cycle with data_valid & data_ready, and the buffer may be refilled in that same cycle.
  always_comb begin
    buf_free   = !data_valid || data_ready;
    full       = (bitcnt == BC_FULL);
    stall_c    = enable && full && !buf_free;
    sample     = enable && !stall_c && (cnt == '0);
    completing = sample && (bitcnt == BC_LAST);
    load_buf   = enable && buf_free && (full || completing);
    word_next  = {shreg[WORD_W-2:0], sync_bit};
    // shreg[0] is the previous sample; repcnt==0 marks that there is none yet.
    repcnt_nxt = rep_next(repcnt, (repcnt != '0) && (sync_bit == shreg[0]));
  end

  assign stall = stall_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      shreg      <= '0;
      bitcnt     <= '0;
      repcnt     <= '0;
      enable_q   <= 1'b0;
      rep_err    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      enable_q <= enable;
      if (!enable) begin
        cnt    <= sample_cnt;
        shreg  <= '0;
        bitcnt <= '0;
        repcnt <= '0;
        if (enable_q) begin
          rep_err <= 1'b0;
        end
      end else begin
        if (!stall_c) begin
          cnt <= (cnt == '0) ? sample_cnt : cnt - CNT_W'(1);
        end
        if (sample) begin
          shreg  <= word_next;
          repcnt <= repcnt_nxt;
          if (repcnt_nxt == REP_HIT) begin
            rep_err <= 1'b1;
          end
        end
        // A held full word leaves as a coincident sample starts the next word.
        if (full) begin
          if (buf_free) begin
            bitcnt <= sample ? BC_W'(1) : '0;
          end
        end else if (sample) begin
          bitcnt <= (completing && buf_free) ? '0 : bitcnt + BC_W'(1);
        end
      end
      if (load_buf) begin
        data_out   <= full ? shreg : word_next;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dxm_trng_bit_collector.sv
// Bench for dxm_trng_bit_collector: directed scenarios plus random traffic, scoreboarded
// against a bit-queue reference model of the collector.
module tb_dxm_trng_bit_collector;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int RL = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rosc_in;
  logic          enable;
  logic [CW-1:0] sample_cnt;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          data_ready;
  logic          stall;
  logic          rep_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state
  bit m_bits[$];
  bit m_valid;
  int m_left;
  int m_run;
  bit m_last;
  bit m_err;
  bit m_en_prev;
  bit h1, h2;

  always #5 clk = ~clk;

  dxm_trng_bit_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rosc_in    (rosc_in),
    .enable     (enable),
    .sample_cnt (sample_cnt),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .stall      (stall),
    .rep_err    (rep_err)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Hand the collected bits to the output buffer; first collected bit lands in the MSB.
  function automatic void deliver();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
    exp_q.push_back(w);
    m_bits.delete();
    m_valid = 1'b1;
  endfunction

  always @(posedge clk) begin : model
    bit sbit, free, full, stl;
    sbit = h2;
    h2   = h1;
    h1   = rosc_in;
    if (!rst_n) begin
      m_bits.delete();
      exp_q.delete();
      m_valid = 0; m_left = 0; m_run = 0; m_last = 0;
      m_err = 0; m_en_prev = 0; h1 = 0; h2 = 0;
    end else begin
      free = !m_valid || data_ready;
      full = (m_bits.size() == W);
      stl  = enable && full && !free;
      if (m_valid && data_ready) m_valid = 1'b0;
      if (!enable) begin
        m_bits.delete();
        m_left = int'(sample_cnt);
        m_run  = 0;
        if (m_en_prev) m_err = 1'b0;
      end else if (!stl) begin
        if (full) deliver();
        if (m_left == 0) begin
          m_run  = (m_run > 0 && sbit == m_last) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
          m_last = sbit;
          if (m_run == RL) m_err = 1'b1;
          m_bits.push_back(sbit);
          m_left = int'(sample_cnt);
          if (m_bits.size() == W && free) deliver();
        end else begin
          m_left--;
        end
      end
      m_en_prev = enable;
    end
  end

  // Monitor: per-cycle status compare plus word scoreboard on each accepted handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      check("data_valid", W'(data_valid), W'(m_valid));
      check("stall", W'(stall), W'(enable && m_bits.size() == W && m_valid && !data_ready));
      check("rep_err", W'(rep_err), W'(m_err));
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected actual=%h expected=none at %0t", data_out, $time);
        end else begin
          check("word", data_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    rosc_in    = 1'b0;
    enable     = 1'b0;
    sample_cnt = '0;
    data_ready = 1'b1;
    ticks(2);
    check("rst_data_out", data_out, '0);
    check("rst_data_valid", W'(data_valid), '0);
    check("rst_stall", W'(stall), '0);
    check("rst_rep_err", W'(rep_err), '0);
    rst_n = 1'b1;

    // All-ones stream, one sample per clock
    rosc_in = 1'b1;
    ticks(3);
    enable = 1'b1;
    ticks(31);
    check("t1_valid_early", W'(data_valid), '0);
    tick();
    check("t1_valid_c33", W'(data_valid), W'(1));
    check("t1_word", data_out, 32'hFFFF_FFFF);
    check("t1_rep_err", W'(rep_err), W'(1));
    ticks(5);

    // Alternating pattern aligned to a 4-clock sample period
    enable = 1'b0;
    sample_cnt = CW'(3);
    rosc_in = 1'b0;
    ticks(4);
    check("t2_err_cleared", W'(rep_err), '0);
    enable = 1'b1;
    for (int t = 1; t <= 128; t++) begin
      tick();
      rosc_in = 1'(((t + 3) / 4) % 2);
    end
    check("t2_word", data_out, 32'hAAAA_AAAA);
    check("t2_valid", W'(data_valid), W'(1));
    check("t2_rep_err", W'(rep_err), '0);

    // Back-pressure: one word buffered, one held in the shift register
    enable = 1'b0;
    sample_cnt = '0;
    ticks(3);
    data_ready = 1'b0;
    enable = 1'b1;
    for (int t = 0; t < 70; t++) begin
      rosc_in = 1'($urandom_range(0, 1));
      tick();
    end
    check("t3_stall", W'(stall), W'(1));
    check("t3_valid", W'(data_valid), W'(1));
    data_ready = 1'b1;
    for (int t = 0; t < 80; t++) begin
      rosc_in = 1'($urandom_range(0, 1));
      tick();
    end

    // Enable dropped mid-word while a word is buffered
    enable = 1'b0;
    ticks(3);
    data_ready = 1'b0;
    enable = 1'b1;
    for (int t = 0; t < 42; t++) begin
      rosc_in = 1'($urandom_range(0, 1));
      tick();
    end
    enable = 1'b0;
    tick();
    check("t4_buffer_kept", W'(data_valid), W'(1));
    enable = 1'b1;
    for (int t = 0; t < 12; t++) begin
      rosc_in = 1'($urandom_range(0, 1));
      tick();
    end
    data_ready = 1'b1;
    ticks(40);

    // Reset mid-word with a word waiting and rep_err set
    enable = 1'b0;
    rosc_in = 1'b1;
    ticks(3);
    data_ready = 1'b0;
    enable = 1'b1;
    ticks(40);
    check("t5_pre_valid", W'(data_valid), W'(1));
    check("t5_pre_err", W'(rep_err), W'(1));
    rst_n = 1'b0;
    tick();
    check("t5_data_out", data_out, '0);
    check("t5_valid", W'(data_valid), '0);
    check("t5_stall", W'(stall), '0);
    check("t5_rep_err", W'(rep_err), '0);
    rst_n = 1'b1;
    enable = 1'b0;
    data_ready = 1'b1;
    ticks(3);

    // Sample period change mid-period
    sample_cnt = CW'(7);
    tick();
    enable = 1'b1;
    for (int t = 0; t < 140; t++) begin
      if (t == 3) sample_cnt = CW'(1);
      rosc_in = 1'($urandom_range(0, 1));
      tick();
    end

    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      rosc_in    = 1'($urandom_range(0, 1));
      data_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) sample_cnt = CW'($urandom_range(0, 2));
      tick();
    end

    enable = 1'b0;
    data_ready = 1'b1;
    ticks(5);
    check("drained", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
